// File: rtl/ariane_ace.sv
// ACE snoop channel types shared between the interconnect and the L1 data cache snoop port.
package ariane_ace;

  typedef struct packed {
    logic [63:0] addr;
    logic [3:0]  snoop;
    logic [2:0]  prot;
  } ace_ac_chan_t;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } ace_cd_chan_t;

  typedef struct packed {
    logic         ac_valid;
    ace_ac_chan_t ac;
    logic         cr_ready;
    logic         cd_ready;
  } snoop_req_t;

  typedef struct packed {
    logic         ac_ready;
    logic         cr_valid;
    logic [4:0]   cr_resp;
    logic         cd_valid;
    ace_cd_chan_t cd;
  } snoop_resp_t;

endpackage

// File: rtl/std_cache_pkg.sv
// Cache-wide constants: line geometry, ACSNOOP codes, CRRESP bit positions and snoop FSM states.
package std_cache_pkg;

  localparam int unsigned DCACHE_LINE_WIDTH = 128;

  localparam logic [3:0] SNOOP_READ_ONCE     = 4'b0000;
  localparam logic [3:0] SNOOP_READ_SHARED   = 4'b0001;
  localparam logic [3:0] SNOOP_READ_UNIQUE   = 4'b0111;
  localparam logic [3:0] SNOOP_CLEAN_INVALID = 4'b1001;
  localparam logic [3:0] SNOOP_MAKE_INVALID  = 4'b1101;

  localparam int unsigned CR_DATA_TRANSFER = 0;
  localparam int unsigned CR_ERROR         = 1;
  localparam int unsigned CR_PASS_DIRTY    = 2;
  localparam int unsigned CR_IS_SHARED     = 3;
  localparam int unsigned CR_WAS_UNIQUE    = 4;

  typedef enum logic [2:0] {
    SnpIdle,
    SnpAc,
    SnpResp,
    SnpData,
    SnpDone
  } snoop_state_e;

endpackage

// File: rtl/ace_snoop_initiator.sv
// Issues one ACE snoop at a time to an L1 snoop port and returns CRRESP plus the assembled line.
module ace_snoop_initiator
  import std_cache_pkg::*;
#(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned LineWidth = DCACHE_LINE_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [AddrWidth-1:0]    req_addr_i,
  input  logic [3:0]              req_snoop_i,
  output ariane_ace::snoop_req_t  snoop_req_o,
  input  ariane_ace::snoop_resp_t snoop_resp_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [4:0]              rsp_resp_o,
  output logic [LineWidth-1:0]    rsp_data_o,
  output logic                    rsp_err_o
);

  localparam int unsigned LineBeats = LineWidth / 64;
  localparam int unsigned CntWidth  = $clog2(LineBeats) + 1;
  localparam int unsigned OffWidth  = $clog2(LineWidth / 8);
  localparam logic [63:0] OffMask   = (64'd1 << OffWidth) - 64'd1;

  snoop_state_e                state_q;
  logic                        req_ready_q;
  logic                        ac_valid_q;
  logic [63:0]                 addr_q;
  logic [3:0]                  snoop_q;
  logic                        cr_ready_q;
  logic                        cd_ready_q;
  logic                        rsp_valid_q;
  logic [4:0]                  rsp_resp_q;
  logic [LineBeats-1:0][63:0]  data_q;
  logic                        frame_q;
  logic                        err_q;
  logic [CntWidth-1:0]         cnt_q;

  logic                ac_hs;
  logic                cr_hs;
  logic                cd_hs;
  logic                beat_in_range;
  logic                last_exp;
  logic                beat_bad;
  logic                frame_d;
  logic [CntWidth-1:0] cnt_d;

  always_comb begin
    ac_hs         = ac_valid_q & snoop_resp_i.ac_ready;
    cr_hs         = cr_ready_q & snoop_resp_i.cr_valid;
    cd_hs         = cd_ready_q & snoop_resp_i.cd_valid;
    beat_in_range = cnt_q < CntWidth'(LineBeats);
    last_exp      = cnt_q == CntWidth'(LineBeats - 1);
    beat_bad      = cd_hs & (~beat_in_range | (snoop_resp_i.cd.last != last_exp));
    // Counter saturates at LineBeats; surplus beats only raise the framing error.
    cnt_d         = (cd_hs & beat_in_range) ? cnt_q + CntWidth'(1) : cnt_q;
    // A response without DataTransfer must not have been accompanied by any CD beat.
    frame_d       = frame_q | beat_bad |
                    (cr_hs & ~snoop_resp_i.cr_resp[CR_DATA_TRANSFER] & ((cnt_q != '0) | cd_hs));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= SnpIdle;
      req_ready_q <= 1'b1;
      ac_valid_q  <= 1'b0;
      addr_q      <= '0;
      snoop_q     <= '0;
      cr_ready_q  <= 1'b0;
      cd_ready_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_resp_q  <= '0;
      data_q      <= '0;
      frame_q     <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      if (cd_hs && beat_in_range) begin
        data_q[cnt_q[CntWidth-2:0]] <= snoop_resp_i.cd.data;
      end

      case (state_q)
        SnpIdle: begin
          if (req_valid_i) begin
            addr_q      <= 64'(req_addr_i) & ~OffMask;
            snoop_q     <= req_snoop_i;
            cnt_q       <= '0;
            data_q      <= '0;
            rsp_resp_q  <= '0;
            frame_q     <= 1'b0;
            err_q       <= 1'b0;
            req_ready_q <= 1'b0;
            ac_valid_q  <= 1'b1;
            state_q     <= SnpAc;
          end
        end
        SnpAc: begin
          if (ac_hs) begin
            ac_valid_q <= 1'b0;
            cr_ready_q <= 1'b1;
            cd_ready_q <= 1'b1;
            state_q    <= SnpResp;
          end
        end
        SnpResp: begin
          if (cr_hs) begin
            rsp_resp_q <= snoop_resp_i.cr_resp;
            cr_ready_q <= 1'b0;
            if (!snoop_resp_i.cr_resp[CR_DATA_TRANSFER] || cnt_d == CntWidth'(LineBeats)) begin
              cd_ready_q  <= 1'b0;
              rsp_valid_q <= 1'b1;
              err_q       <= snoop_resp_i.cr_resp[CR_ERROR] | frame_d;
              state_q     <= SnpDone;
            end else begin
              state_q <= SnpData;
            end
          end
        end
        SnpData: begin
          if (cd_hs && last_exp) begin
            cd_ready_q  <= 1'b0;
            rsp_valid_q <= 1'b1;
            err_q       <= rsp_resp_q[CR_ERROR] | frame_d;
            state_q     <= SnpDone;
          end
        end
        SnpDone: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= SnpIdle;
          end
        end
        default: state_q <= SnpIdle;
      endcase
    end
  end

  always_comb begin
    snoop_req_o          = '0;
    snoop_req_o.ac_valid = ac_valid_q;
    snoop_req_o.ac.addr  = addr_q;
    snoop_req_o.ac.snoop = snoop_q;
    snoop_req_o.ac.prot  = 3'b000;
    snoop_req_o.cr_ready = cr_ready_q;
    snoop_req_o.cd_ready = cd_ready_q;
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_resp_o  = rsp_resp_q;
  assign rsp_data_o  = data_q;
  assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_ace_snoop_initiator.sv
// Bench for ace_snoop_initiator: directed vector table, random snoops against a beat-list model.
module tb_ace_snoop_initiator;

  localparam int LW = 128;
  localparam int LB = LW / 64;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    req_valid;
  logic                    req_ready;
  logic [63:0]             req_addr;
  logic [3:0]              req_snoop;
  ariane_ace::snoop_req_t  snoop_req;
  ariane_ace::snoop_resp_t snoop_resp;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [4:0]              rsp_resp;
  logic [LW-1:0]           rsp_data;
  logic                    rsp_err;

  int n_checks = 0;
  int n_fail   = 0;

  ace_snoop_initiator #(
    .AddrWidth(64),
    .LineWidth(LW)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .req_snoop_i (req_snoop),
    .snoop_req_o (snoop_req),
    .snoop_resp_i(snoop_resp),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_resp_o  (rsp_resp),
    .rsp_data_o  (rsp_data),
    .rsp_err_o   (rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0]      addr;
    logic [3:0]       snoop;
    logic [4:0]       cr_resp;
    logic [7:0]       n_pre;     // beats offered before CR is done
    logic [7:0]       cr_gap;    // RESP cycles before CR is offered
    logic [7:0]       ac_stall;
    logic [7:0]       hold;      // cycles rsp_ready stays low
    logic [3:0]       flip;      // per-beat inversion of the correct last flag
    logic [3:0][63:0] d;
    logic             req_in_hold;
    logic             use_exp;
    logic [7:0]       exp_lat;   // 8'hff: latency not checked
    logic [4:0]       exp_resp;
    logic             exp_err;
    logic [LW-1:0]    exp_data;
  } txn_t;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic txn_t mk(input logic [63:0] addr, input logic [3:0] snoop,
                              input logic [4:0] cr, input int n_pre, input int gap,
                              input int stall, input int hold, input logic [3:0] flip,
                              input logic [63:0] d0, input logic [63:0] d1, input bit rih,
                              input int lat, input logic [4:0] er, input logic ee,
                              input logic [LW-1:0] ed);
    txn_t t;
    t = '0;
    t.addr = addr; t.snoop = snoop; t.cr_resp = cr;
    t.n_pre = 8'(n_pre); t.cr_gap = 8'(gap); t.ac_stall = 8'(stall); t.hold = 8'(hold);
    t.flip = flip; t.d[0] = d0; t.d[1] = d1; t.d[2] = 64'hdead_beef_0000_0002;
    t.req_in_hold = rih; t.use_exp = 1'b1; t.exp_lat = 8'(lat);
    t.exp_resp = er; t.exp_err = ee; t.exp_data = ed;
    return t;
  endfunction

  task automatic run_txn(input txn_t t, input string tag);
    int cyc, bi, nb, ac_wait, resp_cyc, guard;
    bit cr_done, cr_drv, cd_drv;
    logic [63:0] acc_d[$];
    bit acc_l[$];
    logic [4:0] ex_resp;
    logic [LW-1:0] ex_data;
    logic ex_err;
    nb = t.cr_resp[0] ? ((int'(t.n_pre) > LB) ? int'(t.n_pre) : LB) : int'(t.n_pre);
    bi = 0; ac_wait = 0; resp_cyc = 0; cr_done = 0;

    @(negedge clk);
    req_valid = 1'b1; req_addr = t.addr; req_snoop = t.snoop;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      chk({tag, " req_accept_timeout"}, req_ready, 1'b1);
      req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1;
    chk({tag, " ac_valid_cycle1"}, snoop_req.ac_valid, 1'b1);

    while (cyc < 200 && !rsp_valid) begin
      if (snoop_req.ac_valid) begin
        chk({tag, " ac_addr"}, snoop_req.ac.addr, t.addr & ~64'hf);
        chk({tag, " ac_snoop"}, snoop_req.ac.snoop, t.snoop);
        chk({tag, " ac_prot"}, snoop_req.ac.prot, 3'b000);
      end
      snoop_resp.ac_ready = snoop_req.ac_valid && (ac_wait >= int'(t.ac_stall));
      if (snoop_req.ac_valid && !snoop_resp.ac_ready) ac_wait++;
      cr_drv = !cr_done && (resp_cyc >= int'(t.cr_gap));
      cd_drv = (bi < nb) && ((bi < int'(t.n_pre)) || cr_done);
      snoop_resp.cr_valid = cr_drv;
      snoop_resp.cr_resp  = t.cr_resp;
      snoop_resp.cd_valid = cd_drv;
      snoop_resp.cd.data  = cd_drv ? t.d[bi] : 64'h0;
      snoop_resp.cd.last  = cd_drv ? ((bi == LB - 1) ^ t.flip[bi]) : 1'b0;
      if (cd_drv && snoop_req.cd_ready) begin
        acc_d.push_back(t.d[bi]);
        acc_l.push_back((bi == LB - 1) ^ t.flip[bi]);
        bi++;
      end
      if (cr_drv && snoop_req.cr_ready) cr_done = 1'b1;
      if (snoop_req.cr_ready) resp_cyc++;
      @(negedge clk);
      cyc++;
    end
    snoop_resp = '0;
    if (!rsp_valid) begin
      chk({tag, " rsp_timeout"}, rsp_valid, 1'b1);
      return;
    end

    // Reference: CRRESP passes through, line is the first LB accepted beats in order,
    // error = CRRESP.Error | data without DataTransfer | surplus beats | misplaced last.
    ex_resp = t.cr_resp;
    ex_data = '0;
    ex_err  = t.cr_resp[1] | (!t.cr_resp[0] && acc_d.size() > 0) | (acc_d.size() > LB);
    for (int i = 0; i < acc_d.size() && i < LB; i++) begin
      ex_data[i*64 +: 64] = acc_d[i];
      if (acc_l[i] != (i == LB - 1)) ex_err = 1'b1;
    end
    if (t.use_exp) begin
      ex_resp = t.exp_resp; ex_data = t.exp_data; ex_err = t.exp_err;
      if (t.exp_lat != 8'hff) chk({tag, " latency"}, cyc, t.exp_lat);
    end
    chk({tag, " rsp_resp"}, rsp_resp, ex_resp);
    chk({tag, " rsp_data"}, rsp_data, ex_data);
    chk({tag, " rsp_err"}, rsp_err, ex_err);

    for (int k = 0; k < int'(t.hold); k++) begin
      if (t.req_in_hold) begin
        req_valid = 1'b1; req_addr = 64'h1234_5670; req_snoop = 4'h9;
      end
      @(negedge clk);
      chk({tag, " hold_valid"}, rsp_valid, 1'b1);
      chk({tag, " hold_req_ready"}, req_ready, 1'b0);
      chk({tag, " hold_data"}, rsp_data, ex_data);
      chk({tag, " hold_resp"}, rsp_resp, ex_resp);
      chk({tag, " hold_err"}, rsp_err, ex_err);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, " post_rsp_valid"}, rsp_valid, 1'b0);
    chk({tag, " post_req_ready"}, req_ready, 1'b1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " req_ready"}, req_ready, 1'b1);
    chk({tag, " ac_valid"}, snoop_req.ac_valid, 1'b0);
    chk({tag, " cr_ready"}, snoop_req.cr_ready, 1'b0);
    chk({tag, " cd_ready"}, snoop_req.cd_ready, 1'b0);
    chk({tag, " ac_payload"}, {snoop_req.ac.addr, snoop_req.ac.snoop, snoop_req.ac.prot}, '0);
    chk({tag, " rsp_valid"}, rsp_valid, 1'b0);
    chk({tag, " rsp_err"}, rsp_err, 1'b0);
    chk({tag, " rsp_resp"}, rsp_resp, 5'b0);
    chk({tag, " rsp_data"}, rsp_data, '0);
  endtask

  txn_t tbl[9];
  txn_t rt;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_snoop = '0;
    snoop_resp = '0; rsp_ready = 1'b0;

    tbl[0] = mk(64'h8000_0040, 4'b0001, 5'b01000, 0, 0, 0, 0, 4'b0000, 64'h0, 64'h0, 0,
                3, 5'b01000, 1'b0, '0);
    tbl[1] = mk(64'h8000_1000, 4'b0111, 5'b10101, 0, 0, 0, 0, 4'b0000, 64'h1111, 64'h2222, 0,
                5, 5'b10101, 1'b0, {64'h2222, 64'h1111});
    tbl[2] = mk(64'h0000_1238, 4'b0000, 5'b00001, 2, 2, 3, 0, 4'b0000, 64'haaaa, 64'hbbbb, 0,
                8, 5'b00001, 1'b0, {64'hbbbb, 64'haaaa});
    tbl[3] = mk(64'h4000_0080, 4'b0111, 5'b00001, 0, 0, 0, 0, 4'b0001, 64'h3333, 64'h4444, 0,
                5, 5'b00001, 1'b1, {64'h4444, 64'h3333});
    tbl[4] = mk(64'h4000_00c0, 4'b0001, 5'b00011, 0, 0, 0, 0, 4'b0000, 64'h5555, 64'h6666, 0,
                5, 5'b00011, 1'b1, {64'h6666, 64'h5555});
    tbl[5] = mk(64'h2000_0100, 4'b1001, 5'b10000, 0, 0, 0, 5, 4'b0000, 64'h0, 64'h0, 1,
                3, 5'b10000, 1'b0, '0);
    tbl[6] = mk(64'h2000_0140, 4'b0111, 5'b00001, 2, 1, 0, 0, 4'b0000, 64'h7777, 64'h8888, 0,
                4, 5'b00001, 1'b0, {64'h8888, 64'h7777});
    tbl[7] = mk(64'h2000_0180, 4'b0000, 5'b00100, 1, 0, 0, 0, 4'b0000, 64'h9999, 64'h0, 0,
                3, 5'b00100, 1'b1, {64'h0, 64'h9999});
    tbl[8] = mk(64'h2000_01c0, 4'b1101, 5'b00010, 0, 0, 0, 0, 4'b0000, 64'h0, 64'h0, 0,
                3, 5'b00010, 1'b1, '0);

    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("after_reset");

    for (int i = 0; i < 9; i++) begin
      run_txn(tbl[i], $sformatf("vec%0d", i));
    end

    // Reset in DATA: one beat of two taken, then asynchronous reset.
    @(negedge clk);
    req_valid = 1'b1; req_addr = 64'h9000_0000; req_snoop = 4'b0111;
    @(negedge clk);
    req_valid = 1'b0; snoop_resp.ac_ready = 1'b1;
    @(negedge clk);
    snoop_resp.ac_ready = 1'b0; snoop_resp.cr_valid = 1'b1; snoop_resp.cr_resp = 5'b00001;
    @(negedge clk);
    snoop_resp.cr_valid = 1'b0; snoop_resp.cd_valid = 1'b1;
    snoop_resp.cd.data = 64'hcafe; snoop_resp.cd.last = 1'b0;
    @(negedge clk);
    snoop_resp = '0;
    chk("mid_rst pre_cd_ready", snoop_req.cd_ready, 1'b1);
    chk("mid_rst pre_resp", rsp_resp, 5'b00001);
    chk("mid_rst pre_data", rsp_data, {64'h0, 64'hcafe});
    #2 rst = 1'b1;
    #1 chk_reset_vals("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    run_txn(tbl[1], "after_mid_rst");

    for (int n = 0; n < 40; n++) begin
      rt = '0;
      rt.addr     = {$urandom, $urandom};
      rt.snoop    = 4'($urandom);
      rt.cr_resp  = 5'($urandom);
      rt.n_pre    = 8'($urandom_range(0, LB + 1));
      rt.cr_gap   = 8'($urandom_range(0, 3));
      rt.ac_stall = 8'($urandom_range(0, 3));
      rt.hold     = 8'($urandom_range(0, 2));
      rt.flip     = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      for (int b = 0; b < 4; b++) rt.d[b] = {$urandom, $urandom};
      rt.exp_lat  = 8'hff;
      run_txn(rt, $sformatf("rnd%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
